fp_result_scoreboard: RTL and testbench

- Self-checking stage that sits directly downstream of fp_unit in the FPU verification environment.
- On each issued operation it queues the expected result and flags from the test vector.
- When fp_unit asserts ready it pops the oldest entry, compares it with the calculated result and flags, and keeps pass/fail statistics.
- It captures the first failure and can halt checking. This replaces ad-hoc pipeline-depth bookkeeping, so fp_unit latency may vary.

---
 rtl/fp_result_scoreboard.sv | 182 ++++++++++++++++++
 tb/tb_fp_result_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_scoreboard.sv
// Result checker downstream of fp_unit: queues expected results on issue and
// compares them in order against fp_unit outputs, keeping pass/fail statistics.
module fp_result_scoreboard #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int HALT_ON_FAIL = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     issue_valid,
  input  logic [31:0]              issue_result,
  input  logic [4:0]               issue_flags,
  input  logic                     issue_nan_mask,
  input  logic                     fpu_ready,
  input  logic [31:0]              fpu_result,
  input  logic [4:0]               fpu_flags,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic                     mismatch,
  output logic [31:0]              fail_result_diff,
  output logic [4:0]               fail_flags_diff,
  output logic [31:0]              fail_expected,
  output logic [31:0]              fail_calc,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 38;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT1    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR1    = PTR_W'(1);
  localparam logic [CNT_W-1:0] STAT1   = CNT_W'(1);
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef enum logic {RUN = 1'b0, FAILED = 1'b1} state_e;

  logic [ENT_W-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] passCount_q, passCount_d, failCount_q, failCount_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [31:0]      failRdiff_q, failRdiff_d, failExp_q, failExp_d, failCalc_q, failCalc_d;
  logic [4:0]       failFdiff_q, failFdiff_d;

  logic             isFull, isEmpty, doPush, doPop, isMatch;
  logic [ENT_W-1:0] headEntry;
  logic [31:0]      expResult, rdiff;
  logic [4:0]       expFlags, fdiff;
  logic             expMask;

  always_comb begin
    isFull    = (count_q == DEPTH_C);
    isEmpty   = (count_q == '0);
    doPop     = fpu_ready && !isEmpty;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    doPush    = issue_valid && (!isFull || doPop);
    headEntry = mem[rdPtr_q];
    expResult = headEntry[37:6];
    expFlags  = headEntry[5:1];
    expMask   = headEntry[0];
    rdiff     = expResult ^ fpu_result;
    fdiff     = expFlags ^ fpu_flags;
    if (expMask && (expResult == QNAN)) begin
      rdiff[21:0] = '0;
      rdiff[31]   = 1'b0;
    end
    isMatch = (rdiff == '0) && (fdiff == '0);
  end

  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    passCount_d = passCount_q;
    failCount_d = failCount_q;
    mismatch_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    failRdiff_d = failRdiff_q;
    failFdiff_d = failFdiff_q;
    failExp_d   = failExp_q;
    failCalc_d  = failCalc_q;

    if (doPush) wrPtr_d = wrPtr_q + PTR1;
    if (doPop)  rdPtr_d = rdPtr_q + PTR1;
    if (doPush && !doPop)      count_d = count_q + CNT1;
    else if (!doPush && doPop) count_d = count_q - CNT1;

    if (issue_valid && isFull && !doPop) overflow_d  = 1'b1;
    if (fpu_ready && isEmpty)            underflow_d = 1'b1;

    if (doPop && (state_q == RUN)) begin
      if (isMatch) begin
        if (passCount_q != '1) passCount_d = passCount_q + STAT1;
      end else begin
        mismatch_d = 1'b1;
        if (failCount_q != '1) failCount_d = failCount_q + STAT1;
        if (failCount_q == '0) begin
          failRdiff_d = rdiff;
          failFdiff_d = fdiff;
          failExp_d   = expResult;
          failCalc_d  = fpu_result;
        end
        if (HALT_ON_FAIL != 0) state_d = FAILED;
      end
    end

    if (clear) begin
      state_d     = RUN;
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      passCount_d = '0;
      failCount_d = '0;
      mismatch_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      failRdiff_d = '0;
      failFdiff_d = '0;
      failExp_d   = '0;
      failCalc_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      passCount_q <= '0;
      failCount_q <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      failRdiff_q <= '0;
      failFdiff_q <= '0;
      failExp_q   <= '0;
      failCalc_q  <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      passCount_q <= passCount_d;
      failCount_q <= failCount_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      failRdiff_q <= failRdiff_d;
      failFdiff_q <= failFdiff_d;
      failExp_q   <= failExp_d;
      failCalc_q  <= failCalc_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr_q] <= {issue_result, issue_flags, issue_nan_mask};
  end

  assign pass_count       = passCount_q;
  assign fail_count       = failCount_q;
  assign mismatch         = mismatch_q;
  assign fail_result_diff = failRdiff_q;
  assign fail_flags_diff  = failFdiff_q;
  assign fail_expected    = failExp_q;
  assign fail_calc        = failCalc_q;
  assign pending          = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign halted           = (state_q == FAILED);

endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Bench for fp_result_scoreboard: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fp_result_scoreboard;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int HALT    = 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset, clear, issue_valid, issue_nan_mask, fpu_ready;
  logic [31:0] issue_result, fpu_result;
  logic [4:0]  issue_flags, fpu_flags;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic        mismatch, overflow, underflow, halted;
  logic [31:0] fail_result_diff, fail_expected, fail_calc;
  logic [4:0]  fail_flags_diff;
  logic [$clog2(DEPTH):0] pending;

  fp_result_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W), .HALT_ON_FAIL(HALT)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .issue_valid(issue_valid), .issue_result(issue_result), .issue_flags(issue_flags),
    .issue_nan_mask(issue_nan_mask), .fpu_ready(fpu_ready), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags), .pass_count(pass_count), .fail_count(fail_count),
    .mismatch(mismatch), .fail_result_diff(fail_result_diff), .fail_flags_diff(fail_flags_diff),
    .fail_expected(fail_expected), .fail_calc(fail_calc), .pending(pending),
    .overflow(overflow), .underflow(underflow), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    logic        mask;
  } entry_t;

  // Reference model: an in-order queue of expectations plus the statistics it implies.
  entry_t      mQ[$];
  int          mPass, mFail;
  logic        mMis, mOvf, mUnf, mHalt;
  logic [31:0] mRdiff, mExp, mCalc;
  logic [4:0]  mFdiff;

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPass = 0; mFail = 0;
    mMis = 0; mOvf = 0; mUnf = 0; mHalt = 0;
    mRdiff = 0; mExp = 0; mCalc = 0; mFdiff = 0;
  endtask

  task automatic modelStep();
    entry_t      e;
    logic        popping, wasFull, quietOk;
    logic [31:0] rd;
    logic [4:0]  fd;
    if (clear) begin
      modelReset();
      return;
    end
    mMis    = 0;
    popping = fpu_ready && (mQ.size() != 0);
    wasFull = (mQ.size() == DEPTH);
    if (fpu_ready && mQ.size() == 0) mUnf = 1;
    if (popping) begin
      e = mQ.pop_front();
      if (!mHalt) begin
        // A canonical-NaN expectation with the mask set accepts any quiet NaN of either sign.
        quietOk = e.mask && (e.res == 32'h7FC00000);
        rd = e.res ^ fpu_result;
        if (quietOk) rd = rd & 32'h7FC00000;
        fd = e.flags ^ fpu_flags;
        if (rd == 0 && fd == 0) begin
          if (mPass < CNT_MAX) mPass++;
        end else begin
          if (mFail == 0) begin
            mRdiff = rd; mFdiff = fd; mExp = e.res; mCalc = fpu_result;
          end
          if (mFail < CNT_MAX) mFail++;
          mMis = 1;
          if (HALT != 0) mHalt = 1;
        end
      end
    end
    if (issue_valid) begin
      if (wasFull && !popping) mOvf = 1;
      else mQ.push_back('{issue_result, issue_flags, issue_nan_mask});
    end
  endtask

  task automatic checkOutput();
    checkVal("pass_count", 32'(pass_count), 32'(mPass));
    checkVal("fail_count", 32'(fail_count), 32'(mFail));
    checkVal("mismatch", 32'(mismatch), 32'(mMis));
    checkVal("fail_result_diff", fail_result_diff, mRdiff);
    checkVal("fail_flags_diff", 32'(fail_flags_diff), 32'(mFdiff));
    checkVal("fail_expected", fail_expected, mExp);
    checkVal("fail_calc", fail_calc, mCalc);
    checkVal("pending", 32'(pending), 32'(mQ.size()));
    checkVal("overflow", 32'(overflow), 32'(mOvf));
    checkVal("underflow", 32'(underflow), 32'(mUnf));
    checkVal("halted", 32'(halted), 32'(mHalt));
  endtask

  task automatic applyStimulus(input logic clr, input logic iv, input logic [31:0] ir,
                               input logic [4:0] ifl, input logic im, input logic rdy,
                               input logic [31:0] fr, input logic [4:0] ff);
    clear = clr; issue_valid = iv; issue_result = ir; issue_flags = ifl;
    issue_nan_mask = im; fpu_ready = rdy; fpu_result = fr; fpu_flags = ff;
    @(posedge clock);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic push(input logic [31:0] r, input logic [4:0] f, input logic m);
    applyStimulus(0, 1, r, f, m, 0, 0, 0);
  endtask

  task automatic pop(input logic [31:0] r, input logic [4:0] f);
    applyStimulus(0, 0, 0, 0, 0, 1, r, f);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doClear();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ir;
    logic [4:0]  ifl;
    logic        im;
    logic        rdy;
    logic [31:0] fr;
    logic [4:0]  ff;
    int          expPass;
    int          expFail;
    logic        expMis;
    int          expPend;
    logic        expHalt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 32'h3F800000, 5'h00, 0, 0, 32'h0,        5'h00, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 32'h40000000, 5'h00, 0, 0, 32'h0,        5'h00, 0, 0, 0, 2, 0};
    vecs[2]  = '{1, 32'h7FC00000, 5'h10, 1, 0, 32'h0,        5'h00, 0, 0, 0, 3, 0};
    vecs[3]  = '{0, 32'h0,        5'h00, 0, 0, 32'h0,        5'h00, 0, 0, 0, 3, 0};
    vecs[4]  = '{0, 32'h0,        5'h00, 0, 0, 32'h0,        5'h00, 0, 0, 0, 3, 0};
    vecs[5]  = '{0, 32'h0,        5'h00, 0, 1, 32'h3F800000, 5'h00, 1, 0, 0, 2, 0};
    vecs[6]  = '{0, 32'h0,        5'h00, 0, 1, 32'h40000000, 5'h00, 2, 0, 0, 1, 0};
    vecs[7]  = '{0, 32'h0,        5'h00, 0, 1, 32'h7FFFFFFF, 5'h10, 3, 0, 0, 0, 0};
    vecs[8]  = '{0, 32'h0,        5'h00, 0, 0, 32'h0,        5'h00, 3, 0, 0, 0, 0};
    vecs[9]  = '{1, 32'h3F800000, 5'h01, 0, 0, 32'h0,        5'h00, 3, 0, 0, 1, 0};
    vecs[10] = '{0, 32'h0,        5'h00, 0, 1, 32'h3F800001, 5'h01, 3, 1, 1, 0, 1};
    vecs[11] = '{0, 32'h0,        5'h00, 0, 0, 32'h0,        5'h00, 3, 1, 0, 0, 1};

    reset = 1; clear = 0; issue_valid = 0; issue_result = 0; issue_flags = 0;
    issue_nan_mask = 0; fpu_ready = 0; fpu_result = 0; fpu_flags = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput();
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].iv, vecs[i].ir, vecs[i].ifl, vecs[i].im,
                    vecs[i].rdy, vecs[i].fr, vecs[i].ff);
      checkVal($sformatf("vec%0d_pass", i), 32'(pass_count), 32'(vecs[i].expPass));
      checkVal($sformatf("vec%0d_fail", i), 32'(fail_count), 32'(vecs[i].expFail));
      checkVal($sformatf("vec%0d_mismatch", i), 32'(mismatch), 32'(vecs[i].expMis));
      checkVal($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].expPend));
      checkVal($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].expHalt));
    end
    checkVal("first_fail_diff", fail_result_diff, 32'h00000001);
    checkVal("first_fail_expected", fail_expected, 32'h3F800000);
    checkVal("first_fail_calc", fail_calc, 32'h3F800001);

    // Halted: further pops move pointers but leave statistics and capture alone.
    push(32'h0000AAAA, 5'h00, 0);
    pop(32'h0000BBBB, 5'h00);
    checkVal("halted_fail_frozen", 32'(fail_count), 32'd1);
    checkVal("halted_no_pulse", 32'(mismatch), 32'd0);
    checkVal("halted_capture_kept", fail_calc, 32'h3F800001);
    checkVal("halted_pending", 32'(pending), 32'd0);

    doClear();
    checkVal("clear_halted", 32'(halted), 32'd0);
    checkVal("clear_fail", 32'(fail_count), 32'd0);
    checkVal("clear_pass", 32'(pass_count), 32'd0);

    // Canonical-NaN relaxation only applies with the mask set.
    push(32'h7FC00000, 5'h00, 0);
    pop(32'hFFC00000, 5'h00);
    checkVal("nan_nomask_diff", fail_result_diff, 32'h80000000);
    checkVal("nan_nomask_fail", 32'(fail_count), 32'd1);
    doClear();
    push(32'h7FC00000, 5'h00, 1);
    pop(32'hFFC00000, 5'h00);
    checkVal("nan_mask_pass", 32'(pass_count), 32'd1);
    checkVal("nan_mask_fail", 32'(fail_count), 32'd0);

    // Overflow: the extra push is dropped and order is preserved.
    doClear();
    for (int i = 0; i <= DEPTH; i++) push(32'h100 + 32'(i), 5'h00, 0);
    checkVal("ovf_flag", 32'(overflow), 32'd1);
    checkVal("ovf_pending", 32'(pending), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop(32'h100 + 32'(i), 5'h00);
    checkVal("ovf_drain_pass", 32'(pass_count), 32'(DEPTH));
    checkVal("ovf_drain_fail", 32'(fail_count), 32'd0);

    // Full FIFO with push and pop together must not overflow.
    doClear();
    for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(i), 5'h00, 0);
    applyStimulus(0, 1, 32'h300, 5'h00, 0, 1, 32'h200, 5'h00);
    checkVal("full_pushpop_ovf", 32'(overflow), 32'd0);
    checkVal("full_pushpop_pending", 32'(pending), 32'(DEPTH));

    // Underflow with a simultaneous push keeps the new entry uncompared.
    doClear();
    applyStimulus(0, 1, 32'h00000055, 5'h02, 0, 1, 32'h12345678, 5'h00);
    checkVal("unf_flag", 32'(underflow), 32'd1);
    checkVal("unf_pending", 32'(pending), 32'd1);
    checkVal("unf_counts", 32'(pass_count) + 32'(fail_count), 32'd0);
    checkVal("unf_no_pulse", 32'(mismatch), 32'd0);
    pop(32'h00000055, 5'h02);
    checkVal("unf_next_pass", 32'(pass_count), 32'd1);

    // Asynchronous reset mid-stream.
    doClear();
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i), 5'h00, 0);
    #2;
    reset = 1;
    #1;
    modelReset();
    checkOutput();
    checkVal("async_rst_pending", 32'(pending), 32'd0);
    @(posedge clock);
    #1;
    reset = 0;
    checkOutput();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        clr, iv, im, rdy;
      logic [31:0] ir, fr;
      logic [4:0]  ifl, ff;
      int          mode;
      clr = ($urandom_range(0, 79) == 0);
      iv  = ($urandom_range(0, 99) < (((i / 60) % 2 == 0) ? 70 : 35));
      rdy = ($urandom_range(0, 99) < (((i / 60) % 2 == 0) ? 35 : 70));
      case ($urandom_range(0, 3))
        0:       ir = 32'h7FC00000;
        1:       ir = 32'h3F800000;
        default: ir = $urandom;
      endcase
      ifl = 5'($urandom);
      im  = 1'($urandom);
      if (mQ.size() != 0) begin
        fr   = mQ[0].res;
        ff   = mQ[0].flags;
        mode = $urandom_range(0, 19);
        if (mode == 0)      fr = fr ^ (32'h1 << $urandom_range(0, 31));
        else if (mode == 1) ff = ff ^ (5'h1 << $urandom_range(0, 4));
        else if (mode < 5)  fr = 32'h7FC00000 | ($urandom & 32'h803FFFFF);
      end else begin
        fr = $urandom;
        ff = 5'($urandom);
      end
      applyStimulus(clr, iv, ir, ifl, im, rdy, fr, ff);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
